sobel_frame_ctrl: RTL and testbench

SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

---
 rtl/sobel_ctrl_pkg.sv | 22 ++
 rtl/pix_xy_counter.sv | 58 +++++
 rtl/sobel_frame_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_ctrl_pkg.sv
// Shared types and defaults for the Sobel frame controller: FSM state
// encoding, default frame geometry and a counter-width helper.
package sobel_ctrl_pkg;

  localparam int DEF_IMG_W     = 640;
  localparam int DEF_IMG_H     = 480;
  localparam int DEF_FLUSH_LEN = 648;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACTIVE,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // Width needed to index 0..n-1, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pix_xy_counter.sv
// Raster position counter: x wraps at W-1 and advances y, y wraps at H-1.
// Used for both the camera-input and pipeline-output sides of the frame.
module pix_xy_counter
  import sobel_ctrl_pkg::*;
#(
  parameter int W = DEF_IMG_W,
  parameter int H = DEF_IMG_H
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  output logic [cnt_w(W)-1:0] x,
  output logic [cnt_w(H)-1:0] y,
  output logic                last
);

  localparam int XW = cnt_w(W);
  localparam int YW = cnt_w(H);
  localparam logic [XW-1:0] X_MAX = XW'(W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(H - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer wrapping a Sobel pipeline: clears line buffers, gates pixels,
// flushes with zero pixels and counts outputs. Define SOBEL_BORDER_MASK_EN to flag border outputs.
module sobel_frame_ctrl
  import sobel_ctrl_pkg::*;
#(
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int FLUSH_LEN = DEF_FLUSH_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic                    pipe_oen,
  output logic                    pipe_en,
  output logic                    pipe_zero,
  output logic                    pipe_aclr,
  output logic [cnt_w(IMG_W)-1:0] in_x,
  output logic [cnt_w(IMG_H)-1:0] in_y,
  output logic                    out_valid,
  output logic                    out_sof,
  output logic                    out_eol,
  output logic                    out_mask,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    overrun
);

  localparam int XW = cnt_w(IMG_W);
  localparam int YW = cnt_w(IMG_H);
  localparam int FW = cnt_w(FLUSH_LEN + 1);
  localparam logic [FW-1:0] FLUSH_MAX = FW'(FLUSH_LEN);
  localparam logic [XW-1:0] X_MAX     = XW'(IMG_W - 1);

  state_e        state_q, state_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic          out_full_q, out_full_d;
  logic          overrun_q, overrun_d;
  logic          pipe_en_q, pipe_en_d;
  logic          pipe_zero_q, pipe_zero_d;
  logic          pipe_aclr_q, pipe_aclr_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sof_q, out_sof_d;
  logic          out_eol_q, out_eol_d;
  logic          frame_done_q, frame_done_d;
  logic          busy_q, busy_d;

  logic          start_acc, in_take, in_last, out_take, out_last, flush_issue;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign in_take   = (state_q == ST_ACTIVE) && in_valid;
  // Outputs beyond the frame size, or while idle, are not counted.
  assign out_take  = pipe_oen && (state_q != ST_IDLE) && !out_full_q;

  pix_xy_counter #(.W(IMG_W), .H(IMG_H)) u_in_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .en   (in_take),
    .x    (in_x),
    .y    (in_y),
    .last (in_last)
  );

  pix_xy_counter #(.W(IMG_W), .H(IMG_H)) u_out_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .en   (out_take),
    .x    (out_x),
    .y    (out_y),
    .last (out_last)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    out_full_d  = out_full_q || (out_take && out_last);
    overrun_d   = overrun_q;
    flush_issue = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_CLEAR;
          flush_cnt_d = '0;
          out_full_d  = 1'b0;
          overrun_d   = 1'b0;
        end
      end
      ST_CLEAR: begin
        state_d = ST_ACTIVE;
        if (in_valid) overrun_d = 1'b1;
      end
      ST_ACTIVE: begin
        if (in_take && in_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (in_valid) overrun_d = 1'b1;
        // Completion of the output side ends the frame even mid-flush.
        if (out_full_q) begin
          state_d = ST_DONE;
        end else if (flush_cnt_q < FLUSH_MAX) begin
          flush_issue = 1'b1;
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs, aligned one cycle after the decision that produces them.
  always_comb begin
    pipe_en_d    = in_take || flush_issue;
    pipe_zero_d  = flush_issue;
    pipe_aclr_d  = (state_d == ST_CLEAR);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
    out_valid_d  = out_take;
    out_sof_d    = out_take && (out_x == '0) && (out_y == '0);
    out_eol_d    = out_take && (out_x == X_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      flush_cnt_q  <= '0;
      out_full_q   <= 1'b0;
      overrun_q    <= 1'b0;
      pipe_en_q    <= 1'b0;
      pipe_zero_q  <= 1'b0;
      pipe_aclr_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eol_q    <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      out_full_q   <= out_full_d;
      overrun_q    <= overrun_d;
      pipe_en_q    <= pipe_en_d;
      pipe_zero_q  <= pipe_zero_d;
      pipe_aclr_q  <= pipe_aclr_d;
      out_valid_q  <= out_valid_d;
      out_sof_q    <= out_sof_d;
      out_eol_q    <= out_eol_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

`ifdef SOBEL_BORDER_MASK_EN
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
  logic out_mask_q, out_mask_d;

  always_comb begin
    out_mask_d = out_take && ((out_x == '0) || (out_x == X_MAX) ||
                              (out_y == '0) || (out_y == Y_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_mask_q <= 1'b0;
    else     out_mask_q <= out_mask_d;
  end

  assign out_mask = out_mask_q;
`else
  assign out_mask = 1'b0;
`endif

  assign pipe_en    = pipe_en_q;
  assign pipe_zero  = pipe_zero_q;
  assign pipe_aclr  = pipe_aclr_q;
  assign out_valid  = out_valid_q;
  assign out_sof    = out_sof_q;
  assign out_eol    = out_eol_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl on a 4x3 frame with a 6-cycle flush;
// stimulus pushes expectations, a negedge monitor pops and compares.
module tb_sobel_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int FL = 6;
  localparam int N  = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       pipe_oen = 1'b0;
  logic       pipe_en, pipe_zero, pipe_aclr;
  logic [1:0] in_x, in_y;
  logic       out_valid, out_sof, out_eol, out_mask, frame_done, busy, overrun;

  sobel_frame_ctrl #(.IMG_W(W), .IMG_H(H), .FLUSH_LEN(FL)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .pipe_oen   (pipe_oen),
    .pipe_en    (pipe_en),
    .pipe_zero  (pipe_zero),
    .pipe_aclr  (pipe_aclr),
    .in_x       (in_x),
    .in_y       (in_y),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_mask   (out_mask),
    .frame_done (frame_done),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic sof;
    logic eol;
    logic mask;
    logic last;
  } out_exp_t;

  out_exp_t out_exp_q[$];
  bit       zero_exp_q[$];
  out_exp_t mon_e;
  int n_checks = 0;
  int n_pass = 0;
  int aclr_seen = 0;
  int done_seen = 0;
  int done_dly = 0;
  bit ov_model = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic is_border(input int k);
`ifdef SOBEL_BORDER_MASK_EN
    int x = k % W;
    int y = k / W;
    return (x == 0) || (x == W - 1) || (y == 0) || (y == H - 1);
`else
    return 1'b0 && (k < 0);
`endif
  endfunction

  // Monitor: pops expectations whenever the DUT presents pipeline or output activity.
  always @(negedge clk) begin
    if (!rst) begin
      case (done_dly)
        1: begin check("frame_done_after_last", frame_done, 1); done_dly = 2; end
        2: begin check("busy_low_after_done", busy, 0); done_dly = 0; end
        default: ;
      endcase
      if (pipe_aclr) aclr_seen++;
      if (frame_done) done_seen++;
      if (pipe_en) begin
        if (zero_exp_q.size() == 0) check("pipe_en_unexpected", pipe_en, 0);
        else check("pipe_zero", pipe_zero, zero_exp_q.pop_front());
      end else if (pipe_zero) begin
        check("pipe_zero_without_en", pipe_zero, 0);
      end
      if (out_valid) begin
        if (out_exp_q.size() == 0) begin
          check("out_valid_unexpected", out_valid, 0);
        end else begin
          mon_e = out_exp_q.pop_front();
          check("out_sof", out_sof, mon_e.sof);
          check("out_eol", out_eol, mon_e.eol);
          check("out_mask", out_mask, mon_e.mask);
          if (mon_e.last) done_dly = 1;
        end
      end else if (out_sof || out_eol || out_mask) begin
        check("out_flags_without_valid", {out_sof, out_eol, out_mask}, 0);
      end
    end
  end

  // ov_mode: 0 none, 1 in_valid during CLEAR, 2 in_valid during FLUSH.
  task automatic run_frame(input bit gaps, input bit start_act, input int ov_mode,
                           input int extra, input bit start_done);
    int aclr0 = aclr_seen;
    int done0 = done_seen;
    int t = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ov_model = 1'b0;
    check("overrun_cleared_by_start", overrun, 0);
    check("busy_in_clear", busy, 1);
    if (ov_mode == 1) begin in_valid = 1'b1; ov_model = 1'b1; end
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          start = start_act && ($urandom_range(0, 1) == 1);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      start    = start_act && ($urandom_range(0, 1) == 1);
      zero_exp_q.push_back(1'b0);
      @(negedge clk);
      check("in_x", in_x, k % W);
      check("in_y", in_y, k / W);
      @(posedge clk); #1 in_valid = 1'b0; start = 1'b0;
    end
    repeat (FL) zero_exp_q.push_back(1'b1);
    if (ov_mode == 2) begin
      in_valid = 1'b1; ov_model = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
    end
    check("in_xy_wrap", {in_y, in_x}, 0);
    check("overrun_after_input", overrun, ov_model);
    while (zero_exp_q.size() != 0 && t < 60) begin @(negedge clk); t++; end
    check("flush_drained", zero_exp_q.size(), 0);
    @(posedge clk); #1;
    for (int k = 0; k < N + extra; k++) begin
      if (gaps && k < N) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      pipe_oen = 1'b1;
      if (k < N) out_exp_q.push_back('{sof: (k == 0), eol: (k % W == W - 1),
                                        mask: is_border(k), last: (k == N - 1)});
      @(posedge clk); #1 pipe_oen = 1'b0;
    end
    if (start_done) begin
      start = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1 start = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
    check("busy_idle_after_frame", busy, 0);
    check("frame_done_count", done_seen - done0, 1);
    check("pipe_aclr_cycles", aclr_seen - aclr0, 1);
    check("outputs_all_seen", out_exp_q.size(), 0);
    check("overrun_held", overrun, ov_model);
  endtask

  // In IDLE, pixels and pipeline outputs must be ignored without error.
  task automatic idle_noise();
    repeat (4) begin
      in_valid = ($urandom_range(0, 1) == 1);
      pipe_oen = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; pipe_oen = 1'b0;
    @(posedge clk); #1;
    check("idle_overrun", overrun, ov_model);
    check("idle_busy", busy, 0);
  endtask

  task automatic reset_mid_frame();
    int done0 = done_seen;
    int aclr0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 in_valid = 1'b1;
    repeat (6) begin zero_exp_q.push_back(1'b0); @(posedge clk); #1; end
    in_valid = 1'b0;
    check("pre_reset_xy", {in_y, in_x}, {2'd1, 2'd2});
    rst = 1'b1;
    #1;
    check("reset_all_outputs_zero",
          {pipe_en, pipe_zero, pipe_aclr, in_x, in_y, out_valid, out_sof, out_eol,
           out_mask, frame_done, busy, overrun}, 0);
    zero_exp_q.delete();
    ov_model = 1'b0;
    aclr0 = aclr_seen;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("no_done_after_reset", done_seen - done0, 0);
    check("no_clear_after_reset", aclr_seen - aclr0, 0);
    check("idle_after_reset", busy, 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("reset_state",
          {pipe_en, pipe_zero, pipe_aclr, in_x, in_y, out_valid, out_sof, out_eol,
           out_mask, frame_done, busy, overrun}, 0);
    @(posedge clk); #1 rst = 1'b0;

    run_frame(1'b0, 1'b0, 0, 0, 1'b0);
    idle_noise();
    run_frame(1'b1, 1'b1, 2, 2, 1'b0);
    idle_noise();
    run_frame(1'b1, 1'b0, 1, 0, 1'b1);
    reset_mid_frame();
    run_frame(1'b0, 1'b0, 0, 2, 1'b0);
    repeat (3) begin
      run_frame(1'b1, ($urandom_range(0, 1) == 1), 0, $urandom_range(0, 2), 1'b0);
      idle_noise();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
